// File: rtl/fir_host_pkg.sv
// Shared types and defaults for the FIR host driver.
// State encoding and watchdog width helper live here.
package fir_host_pkg;

    localparam int DATA_W_DEF       = 16;
    localparam int NUM_COEFFS_DEF   = 4;
    localparam int WAIT_TIMEOUT_DEF = 15;

    function automatic int tmo_width(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int TMO_W = tmo_width(WAIT_TIMEOUT_DEF);

    typedef enum logic [2:0] {
        IDLE,
        C_HI,
        C_LO,
        S_HI,
        S_LO,
        S_CAP,
        RESULT
    } state_t;

endpackage

// File: rtl/fir_host_driver_if.sv
// System-side streams of the FIR host driver: coefficients,
// samples in, results out, all valid/ready.
interface fir_host_driver_if
    import fir_host_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              coeff_valid;
    logic              coeff_ready;
    logic [DATA_W-1:0] coeff_data;
    logic              samp_valid;
    logic              samp_ready;
    logic [DATA_W-1:0] samp_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_err;

    modport master (
        output coeff_valid, coeff_data,
        input  coeff_ready,
        output samp_valid, samp_data,
        input  samp_ready,
        input  res_valid, res_data, res_err,
        output res_ready
    );

    modport slave (
        input  coeff_valid, coeff_data,
        output coeff_ready,
        input  samp_valid, samp_data,
        output samp_ready,
        output res_valid, res_data, res_err,
        input  res_ready
    );

endinterface

// File: rtl/fir_wait_timer.sv
// Per-state watchdog: counts cycles while enabled, flags the
// last permitted cycle so the FSM can bail out on that edge.
module fir_wait_timer
    import fir_host_pkg::*;
#(
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = tmo_width(WAIT_TIMEOUT);

    logic [W-1:0] cnt;

    assign expired = enable && (cnt == W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_host_driver.sv
// Initiator for the FIR filter strobe/modwait handshake: loads
// coefficients and samples, returns captured results.
module fir_host_driver
    import fir_host_pkg::*;
#(
    parameter int NUM_COEFFS   = NUM_COEFFS_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fir_host_driver_if.slave  bus,
    output logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] fir_coefficient,
    output logic              load_coeff,
    output logic              data_ready,
    input  logic              modwait,
    input  logic [DATA_W-1:0] fir_out,
    input  logic              err,
    input  logic              one_k_samples,
    output logic              coeffs_loaded,
    output logic              timeout,
    output logic [7:0]        kblk_cnt
);

    localparam int IDX_W = $clog2(NUM_COEFFS + 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             idle;
    logic             c_acc;
    logic             s_acc;
    logic             tmr_en;
    logic             tmr_clr;
    logic             expired;

    // Ready is masked by rst so every output reads 0 during reset.
    assign idle = (state == IDLE) && !rst;
    assign bus.coeff_ready = idle;
    assign bus.samp_ready = idle && coeffs_loaded && !bus.coeff_valid;
    assign c_acc = bus.coeff_valid && bus.coeff_ready;
    assign s_acc = bus.samp_valid && bus.samp_ready;

    assign tmr_en = (state == C_HI) || (state == C_LO) ||
                    (state == S_HI) || (state == S_LO);
    assign tmr_clr = (state_next != state);

    fir_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .expired(expired)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (c_acc) begin
                    state_next = C_HI;
                end else if (s_acc) begin
                    state_next = S_HI;
                end
            end
            C_HI: begin
                if (modwait) begin
                    state_next = C_LO;
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            C_LO: begin
                if (!modwait || expired) begin
                    state_next = IDLE;
                end
            end
            S_HI: begin
                if (modwait) begin
                    state_next = S_LO;
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            S_LO: begin
                if (!modwait) begin
                    state_next = S_CAP;
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            S_CAP: state_next = RESULT;
            RESULT: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            sample_data     <= '0;
            fir_coefficient <= '0;
            load_coeff      <= 1'b0;
            data_ready      <= 1'b0;
            coeffs_loaded   <= 1'b0;
            timeout         <= 1'b0;
            kblk_cnt        <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= '0;
            bus.res_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (one_k_samples) begin
                kblk_cnt <= kblk_cnt + 8'd1;
            end
            unique case (state)
                IDLE: begin
                    if (c_acc) begin
                        fir_coefficient <= bus.coeff_data;
                        load_coeff      <= 1'b1;
                        if (coeffs_loaded) begin
                            coeffs_loaded <= 1'b0;
                            idx           <= '0;
                        end
                    end else if (s_acc) begin
                        sample_data <= bus.samp_data;
                        data_ready  <= 1'b1;
                    end
                end
                C_HI: begin
                    if (modwait) begin
                        load_coeff <= 1'b0;
                    end else if (expired) begin
                        load_coeff    <= 1'b0;
                        timeout       <= 1'b1;
                        coeffs_loaded <= 1'b0;
                        idx           <= '0;
                    end
                end
                C_LO: begin
                    if (!modwait) begin
                        if (idx == IDX_W'(NUM_COEFFS - 1)) begin
                            idx           <= '0;
                            coeffs_loaded <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (expired) begin
                        timeout       <= 1'b1;
                        coeffs_loaded <= 1'b0;
                        idx           <= '0;
                    end
                end
                S_HI: begin
                    if (modwait) begin
                        data_ready <= 1'b0;
                    end else if (expired) begin
                        data_ready <= 1'b0;
                        timeout    <= 1'b1;
                    end
                end
                S_LO: begin
                    if (modwait && expired) begin
                        timeout <= 1'b1;
                    end
                end
                S_CAP: begin
                    bus.res_data  <= fir_out;
                    bus.res_err   <= err;
                    bus.res_valid <= 1'b1;
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
